// File: rtl/io_pkg.sv
// Shared definitions for the IO-region peripherals: register offsets,
// STATUS bit positions and the UART transmitter state encoding.
package io_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_PARITY   = 4;

  // PARITY only becomes reachable when the parity build option is enabled
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; DEPTH must be a power
// of two. A pop and a push in the same cycle are both honoured when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // The slot freed by a simultaneous pop makes room for the incoming word
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the IO bus.
// Build option UART_TX_PARITY_EN inserts an even-parity bit before STOP.
module io_uart_tx
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 867,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  uart_tx_state_t   state;
  uart_tx_state_t   state_next;
  logic [DIV_W-1:0] bauddiv;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] bit_cnt;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic             bit_done;
  logic             overflow;
  logic             wr_en;
  logic [1:0]       reg_idx;
  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             busy;
  logic             unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], wdata};

  assign wr_en     = sel && we;
  assign reg_idx   = addr[3:2];
  assign fifo_push = wr_en && (reg_idx == REG_TXDATA);
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign bit_done  = (bit_cnt == div_lat);
  assign busy      = (state != IDLE);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .wdata(wdata[7:0]),
    .pop  (fifo_pop),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // A push is only dropped when the FIFO stays full, i.e. no pop this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bauddiv  <= DIV_W'(DEFAULT_DIV);
      overflow <= 1'b0;
    end else begin
      if (wr_en && (reg_idx == REG_BAUDDIV)) bauddiv <= wdata[DIV_W-1:0];
      if (wr_en && (reg_idx == REG_STATUS))
        overflow <= 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (!fifo_empty) state_next = START;
      START:  if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: if (bit_done) state_next = STOP;
      STOP:   if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every state change happens on a bit-time expiry, so clearing the counter
  // on expiry also reloads it on state entry; the divider is frozen per frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      div_lat <= '0;
      shift   <= '0;
      bit_idx <= '0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      if (!fifo_empty) begin
        shift   <= fifo_head;
        div_lat <= bauddiv;
      end
    end else begin
      bit_cnt <= bit_done ? '0 : bit_cnt + 1'b1;
      if ((state == DATA) && bit_done) begin
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             par_bit <= 1'b0;
    else if ((state == IDLE) && !fifo_empty) par_bit <= ^fifo_head;
  end
`endif

  always_comb begin
    tx = 1'b1;
    case (state)
      START:  tx = 1'b0;
      DATA:   tx = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = par_bit;
`endif
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_empty <= 1'b1;
    else        irq_empty <= fifo_empty && (state == IDLE);
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_idx)
        REG_STATUS: begin
          rdata[STAT_FULL]     = fifo_full;
          rdata[STAT_EMPTY]    = fifo_empty;
          rdata[STAT_BUSY]     = busy;
          rdata[STAT_OVERFLOW] = overflow;
          rdata[STAT_PARITY]   = PARITY_PRESENT;
        end
        REG_BAUDDIV: rdata[DIV_W-1:0] = bauddiv;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Randomised scoreboard bench for io_uart_tx: a transaction-level timeline
// model predicts frame start cycles, register reads and irq_empty.
module tb_io_uart_tx;

  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit HAS_PAR    = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit HAS_PAR    = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq_empty;

  always #5 clk = ~clk;

  io_uart_tx dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx       (tx),
    .irq_empty(irq_empty)
  );

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
    longint      start;
  } frame_t;

  frame_t      sb[$];
  logic [7:0]  model_q[$];
  int unsigned model_div  = 867;
  bit          model_ovf  = 1'b0;
  longint      cyc        = 0;
  longint      next_pop   = 0;
  longint      last_start = -1000000;
  longint      last_f     = 0;
  bit          cond_prev  = 1'b1;
  bit          irq_exp    = 1'b1;
  int          n_checks   = 0;
  int          n_fail     = 0;
  bit          mon_active = 1'b0;
  frame_t      cur;

  function automatic longint frame_len(input int unsigned d);
    return longint'(FRAME_BITS) * (longint'(d) + 1);
  endfunction

  function automatic bit model_busy();
    return (cyc >= last_start) && (cyc < last_start + last_f);
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] r);
    logic [31:0] v;
    v = '0;
    case (r)
      2'd1: begin
        v[0] = (model_q.size() == DEPTH);
        v[1] = (model_q.size() == 0);
        v[2] = model_busy();
        v[3] = model_ovf;
        v[4] = HAS_PAR;
      end
      2'd2: v = model_div;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Line level of a frame at bit position b: start, 8 data LSB first, [parity], stop
  function automatic logic frame_bit(input logic [7:0] d, input longint b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[int'(b) - 1];
    if (HAS_PAR && (b == 9)) return ^d;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    model_q.delete();
    model_div  = 867;
    model_ovf  = 1'b0;
    next_pop   = 0;
    last_start = -1000000;
    last_f     = 0;
    cond_prev  = 1'b1;
    irq_exp    = 1'b1;
  endtask

  // Timeline model: a queued byte starts at the first edge the transmitter is
  // free; a frame of F cycles leaves one idle cycle before the next start
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      cyc++;
      irq_exp = cond_prev;
      if ((cyc >= next_pop) && (model_q.size() > 0)) begin
        frame_t f;
        f.data  = model_q.pop_front();
        f.div   = model_div;
        f.start = cyc;
        sb.push_back(f);
        last_start = cyc;
        last_f     = frame_len(model_div);
        next_pop   = cyc + last_f + 1;
      end
      if (sel && we) begin
        case (addr[3:2])
          2'd0: if (model_q.size() < DEPTH) model_q.push_back(wdata[7:0]);
                else model_ovf = 1'b1;
          2'd1: model_ovf = 1'b0;
          2'd2: model_div = wdata[15:0];
          default: ;
        endcase
      end
      cond_prev = (model_q.size() == 0) && !model_busy();
    end
  end

  // Monitor: a falling tx marks a frame; pop the expected one and check every cycle
  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 1'b0;
      check("tx_in_reset", tx, 1'b1);
    end else begin
      check("irq_empty", irq_empty, irq_exp);
      if (!mon_active && (tx == 1'b0)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_start: tx low at cycle %0d, expected idle high", cyc);
        end else begin
          cur = sb.pop_front();
          check("frame_start_cycle", cyc[31:0], cur.start[31:0]);
          cur.start  = cyc;
          mon_active = 1'b1;
        end
      end
      if (mon_active) begin
        longint k;
        k = cyc - cur.start;
        check("tx_bit", tx, frame_bit(cur.data, k / (longint'(cur.div) + 1)));
        if (k >= frame_len(cur.div) - 1) mon_active = 1'b0;
      end
    end
  end

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input bit s = 1'b1);
    logic [31:0] a;
    @(negedge clk);
    a      = $urandom();
    a[3:2] = r;
    sel    = s;
    we     = 1'b1;
    addr   = a;
    wdata  = d;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic bus_read_check(input logic [1:0] r, input string name);
    logic [31:0] a;
    @(negedge clk);
    a      = $urandom();
    a[3:2] = r;
    sel    = 1'b1;
    we     = 1'b0;
    addr   = a;
    #1;
    check(name, rdata, model_read(r));
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #2;
      if ((model_q.size() == 0) && !model_busy() && (sb.size() == 0) && !mon_active) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL idle_timeout: %0d frames still pending after %0d cycles", sb.size(), max_cycles);
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;

    bus_read_check(2'd1, "status_after_reset");
    check("status_reset_value", rdata, HAS_PAR ? 32'h12 : 32'h2);
    check("tx_idle_after_reset", tx, 1'b1);
    bus_read_check(2'd2, "bauddiv_after_reset");
    check("bauddiv_reset_value", rdata, 32'd867);
    bus_read_check(2'd0, "txdata_reads_zero");
    bus_read_check(2'd3, "reserved_reads_zero");
    @(negedge clk);
    sel = 1'b0;
    addr[3:2] = 2'd1;
    #1;
    check("rdata_unselected", rdata, 32'h0);

    // Single 0x55 frame at 4 cycles per bit, busy checked along the way
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h55);
    bus_idle();
    for (int i = 0; i < 20; i++) bus_read_check(2'd1, "status_during_frame");
    bus_idle();
    wait_idle(2000);

    // Seven back-to-back bytes at divider 0 overrun the FIFO
    bus_write(2'd2, 32'd0);
    for (int i = 0; i < 7; i++) bus_write(2'd0, $urandom_range(0, 255));
    bus_idle();
    bus_read_check(2'd1, "status_after_burst");
    check("overflow_set", rdata[3], 1'b1);
    bus_idle();
    wait_idle(2000);

    bus_write(2'd1, $urandom());
    bus_read_check(2'd1, "status_after_clear");
    check("overflow_cleared", rdata[3], 1'b0);

    // Divider change mid-frame only affects the following frame
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'hA3);
    bus_idle();
    repeat (10) @(negedge clk);
    bus_write(2'd2, 32'd7);
    bus_write(2'd0, $urandom_range(0, 255));
    bus_idle();
    wait_idle(2000);

    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h07);
    bus_idle();
    wait_idle(2000);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: bus_write(2'd0, $urandom_range(0, 255));
        3:       bus_write(2'd2, $urandom_range(0, 3));
        4:       bus_write(2'd1, $urandom());
        5:       bus_write(2'd3, $urandom());
        6:       bus_write(2'($urandom_range(0, 3)), $urandom(), 1'b0);
        default: bus_read_check(2'($urandom_range(0, 3)), "random_read");
      endcase
      if ($urandom_range(0, 3) == 0) begin
        bus_idle();
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
    end
    bus_idle();
    wait_idle(20000);

    // Reset mid-frame: tx must go high with no clock edge and the frame is lost
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'h00);
    bus_idle();
    repeat (20) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("tx_async_reset", tx, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    bus_read_check(2'd1, "status_after_midframe_reset");
    check("status_midframe_reset_value", rdata, HAS_PAR ? 32'h12 : 32'h2);
    bus_idle();
    repeat (80) @(negedge clk);
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
